// File: rtl/mmc1_gen_if.sv
// mmc1_gen_if: CPU/PPU-side pins of the MMC1-class mapper, bundled for the core and its driver.
// Latency: none (plain wires); timing is set by the mapper core on the falling edge of m2.
// Backpressure: none; the CPU bus cannot stall.
// Ports: master drives CPU strobes/data and PPU A12..A10 and reads bank/select lines; slave is the mapper.
// Options: `define OUTER_PRG_EN widens prg_addr_out by one bit (SUROM outer bank).
interface mmc1_gen_if #(
    parameter int PRG_BANK_W = 4,
    parameter int CHR_BANK_W = 5
);
`ifdef OUTER_PRG_EN
    localparam int PRG_OUT_W = PRG_BANK_W + 1;
`else
    localparam int PRG_OUT_W = PRG_BANK_W;
`endif

    logic                  cpu_rw;
    logic                  romsel;
    logic                  cpu_A14;
    logic                  cpu_A13;
    logic                  cpu_D7;
    logic                  cpu_D0;
    logic [2:0]            ppu_addr_in;
    logic                  prg_wram_cs;
    logic                  prg_rom_oe;
    logic [PRG_OUT_W-1:0]  prg_addr_out;
    logic [CHR_BANK_W-1:0] ppu_addr_out;
    logic                  ppu_ciram_a10;
    logic [2:0]            load_count;

    modport master (
        output cpu_rw, romsel, cpu_A14, cpu_A13, cpu_D7, cpu_D0, ppu_addr_in,
        input  prg_wram_cs, prg_rom_oe, prg_addr_out, ppu_addr_out, ppu_ciram_a10, load_count
    );

    modport slave (
        input  cpu_rw, romsel, cpu_A14, cpu_A13, cpu_D7, cpu_D0, ppu_addr_in,
        output prg_wram_cs, prg_rom_oe, prg_addr_out, ppu_addr_out, ppu_ciram_a10, load_count
    );
endinterface

// File: rtl/mmc1_gen.sv
// mmc1_gen: MMC1B-class NES mapper core; serial 5-bit register loads, PRG/CHR banking, mirroring, WRAM/ROM selects.
// Latency: a register commits on the falling m2 edge of the fifth accepted write; outputs are combinational from state.
// Backpressure: none; the CPU bus cannot stall, so back-to-back (RMW) writes are filtered, not held.
// Ports: m2 (sole clock, falling edge), rst_n (async active-low), bus (mmc1_gen_if.slave: CPU strobes/D0/D7,
//        PPU A12..A10 in; PRG/CHR bank lines, CIRAM A10, PRG /OE, WRAM /CS, load_count out).
// Options: `define OUTER_PRG_EN adds a SUROM outer PRG bit on prg_addr_out MSB, sourced from chr_bank_0[4].
module mmc1_gen #(
    parameter int         PRG_BANK_W = 4,
    parameter int         CHR_BANK_W = 5,
    parameter int         WRAM_GATE  = 1,
    parameter logic [4:0] RESET_CTRL = 5'b01100
) (
    input  logic         m2,
    input  logic         rst_n,
    mmc1_gen_if.slave    bus
);

    generate
        if (PRG_BANK_W < 1 || PRG_BANK_W > 4) begin : g_bad_prg_w
            $error("mmc1_gen: PRG_BANK_W must be in 1..4");
        end
        if (CHR_BANK_W < 1 || CHR_BANK_W > 5) begin : g_bad_chr_w
            $error("mmc1_gen: CHR_BANK_W must be in 1..5");
        end
    endgenerate

    logic [4:0] control_q, control_d;
    logic [4:0] chr0_q, chr0_d;
    logic [4:0] chr1_q, chr1_d;
    logic [4:0] prg_q, prg_d;
    logic [3:0] shift_q, shift_d;
    logic [2:0] load_count_q, load_count_d;
    logic       prev_read_q, prev_read_d;
    logic       write_ok;
    logic [4:0] commit_val;

    // A write is only taken when the previous cycle was a read; the second
    // half of an RMW double write therefore never touches state.
    assign write_ok = !bus.cpu_rw && !bus.romsel && prev_read_q;

    always_comb begin
        control_d    = control_q;
        chr0_d       = chr0_q;
        chr1_d       = chr1_q;
        prg_d        = prg_q;
        shift_d      = shift_q;
        load_count_d = load_count_q;
        prev_read_d  = bus.cpu_rw;
        commit_val   = {bus.cpu_D0, shift_q};
        if (write_ok) begin
            if (bus.cpu_D7) begin
                // Shift reset also forces the fix-last-bank PRG mode.
                load_count_d    = 3'd0;
                shift_d         = 4'd0;
                control_d[3:2]  = 2'b11;
            end else if (load_count_q != 3'd4) begin
                shift_d[load_count_q[1:0]] = bus.cpu_D0;
                load_count_d               = load_count_q + 3'd1;
            end else begin
                // Fifth bit: the address of this write picks the target.
                case ({bus.cpu_A14, bus.cpu_A13})
                    2'b00:   control_d = commit_val;
                    2'b01:   chr0_d    = commit_val;
                    2'b10:   chr1_d    = commit_val;
                    default: prg_d     = commit_val;
                endcase
                load_count_d = 3'd0;
                shift_d      = 4'd0;
            end
        end
    end

    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            control_q    <= RESET_CTRL;
            chr0_q       <= 5'd0;
            chr1_q       <= 5'd0;
            prg_q        <= 5'd0;
            shift_q      <= 4'd0;
            load_count_q <= 3'd0;
            prev_read_q  <= 1'b1;
        end else begin
            control_q    <= control_d;
            chr0_q       <= chr0_d;
            chr1_q       <= chr1_d;
            prg_q        <= prg_d;
            shift_q      <= shift_d;
            load_count_q <= load_count_d;
            prev_read_q  <= prev_read_d;
        end
    end

    // PRG banking. Masking bit 0 and OR-ing A14 gives {b[N-1:1], A14}
    // and degenerates cleanly to plain A14 when N == 1.
    logic [PRG_BANK_W-1:0] prg_b;
    logic [PRG_BANK_W-1:0] prg_inner;

    assign prg_b = prg_q[PRG_BANK_W-1:0];

    always_comb begin
        case (control_q[3:2])
            2'b10:   prg_inner = bus.cpu_A14 ? prg_b : '0;
            2'b11:   prg_inner = bus.cpu_A14 ? '1 : prg_b;
            default: prg_inner = (prg_b & ~PRG_BANK_W'(1)) | PRG_BANK_W'(bus.cpu_A14);
        endcase
    end

`ifdef OUTER_PRG_EN
    assign bus.prg_addr_out = {chr0_q[4], prg_inner};
`else
    assign bus.prg_addr_out = prg_inner;
`endif

    // CHR banking; same masking trick for 8 KB mode.
    logic [CHR_BANK_W-1:0] chr0_b;
    logic [CHR_BANK_W-1:0] chr1_b;
    logic                  ppu_a12;

    assign chr0_b  = chr0_q[CHR_BANK_W-1:0];
    assign chr1_b  = chr1_q[CHR_BANK_W-1:0];
    assign ppu_a12 = bus.ppu_addr_in[2];

    assign bus.ppu_addr_out = control_q[4] ? (ppu_a12 ? chr1_b : chr0_b)
                                           : ((chr0_b & ~CHR_BANK_W'(1)) | CHR_BANK_W'(ppu_a12));

    always_comb begin
        case (control_q[1:0])
            2'b00:   bus.ppu_ciram_a10 = 1'b0;
            2'b01:   bus.ppu_ciram_a10 = 1'b1;
            2'b10:   bus.ppu_ciram_a10 = bus.ppu_addr_in[0];
            default: bus.ppu_ciram_a10 = bus.ppu_addr_in[1];
        endcase
    end

    logic wram_gated;
    assign wram_gated = (WRAM_GATE != 0) && prg_q[4];

    assign bus.prg_rom_oe  = bus.cpu_rw ? bus.romsel : 1'b1;
    assign bus.prg_wram_cs = !(m2 && bus.romsel && bus.cpu_A14 && bus.cpu_A13 && !wram_gated);
    assign bus.load_count  = load_count_q;

endmodule

// File: tb/tb_mmc1_gen.sv
module tb_mmc1_gen;
    localparam int PRG_W = 4;
    localparam int CHR_W = 5;
`ifdef OUTER_PRG_EN
    localparam int HAS_OUTER = 1;
`else
    localparam int HAS_OUTER = 0;
`endif

    logic m2;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic last_wram_hi;

    mmc1_gen_if #(.PRG_BANK_W(PRG_W), .CHR_BANK_W(CHR_W)) bus ();

    mmc1_gen #(
        .PRG_BANK_W(PRG_W),
        .CHR_BANK_W(CHR_W),
        .WRAM_GATE (1),
        .RESET_CTRL(5'b01100)
    ) dut (
        .m2   (m2),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial m2 = 1'b0;
    always #10 m2 = ~m2;

    // Reference model: registers as integers, pending serial bits as a queue.
    int m_ctrl, m_chr0, m_chr1, m_prg;
    int m_bits[$];
    bit m_prev_read;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
        m_bits.delete();
        m_prev_read = 1'b1;
    endtask

    task automatic model_step(input bit rw, input bit rs, input bit a14, input bit a13,
                              input bit d7, input bit d0);
        int v;
        if (!rw && !rs && m_prev_read) begin
            if (d7) begin
                m_bits.delete();
                m_ctrl = m_ctrl | 12;
            end else begin
                m_bits.push_back(int'(d0));
                if (m_bits.size() == 5) begin
                    v = 0;
                    for (int i = 0; i < 5; i++) v += m_bits[i] * (2 ** i);
                    case (int'(a14) * 2 + int'(a13))
                        0:       m_ctrl = v;
                        1:       m_chr0 = v;
                        2:       m_chr1 = v;
                        default: m_prg  = v;
                    endcase
                    m_bits.delete();
                end
            end
        end
        m_prev_read = rw;
    endtask

    function automatic int exp_prg(input int a14);
        int b, r;
        b = m_prg % 16;
        case ((m_ctrl / 4) % 4)
            2:       r = (a14 != 0) ? b : 0;
            3:       r = (a14 != 0) ? 15 : b;
            default: r = (b / 2) * 2 + a14;
        endcase
        if (HAS_OUTER != 0) r += ((m_chr0 / 16) % 2) * 16;
        return r;
    endfunction

    function automatic int exp_chr(input int a12);
        if ((m_ctrl / 16) % 2 == 1) return (a12 != 0) ? m_chr1 : m_chr0;
        return (m_chr0 / 2) * 2 + a12;
    endfunction

    function automatic int exp_ciram(input int ppu);
        case (m_ctrl % 4)
            0:       return 0;
            1:       return 1;
            2:       return ppu % 2;
            default: return (ppu / 2) % 2;
        endcase
    endfunction

    function automatic int exp_wram(input int m2v, input int rs, input int a14, input int a13);
        int gated;
        gated = (m_prg / 16) % 2;
        return (m2v == 1 && rs == 1 && a14 == 1 && a13 == 1 && gated == 0) ? 0 : 1;
    endfunction

    // One CPU cycle: drive after rising m2, check high-phase selects, then
    // step the model on the falling edge and check every output.
    task automatic bus_cycle(input bit rw, input bit rs, input bit a14, input bit a13,
                             input bit d7, input bit d0, input bit [2:0] ppu);
        @(posedge m2); #1;
        bus.cpu_rw = rw; bus.romsel = rs; bus.cpu_A14 = a14; bus.cpu_A13 = a13;
        bus.cpu_D7 = d7; bus.cpu_D0 = d0; bus.ppu_addr_in = ppu;
        #1;
        check("wram_cs_hi", bus.prg_wram_cs, exp_wram(1, rs, a14, a13));
        check("rom_oe", bus.prg_rom_oe, rw ? rs : 1);
        last_wram_hi = bus.prg_wram_cs;
        @(negedge m2); #1;
        model_step(rw, rs, a14, a13, d7, d0);
        check("load_count", bus.load_count, m_bits.size());
        check("prg_addr", bus.prg_addr_out, exp_prg(int'(a14)));
        check("chr_addr", bus.ppu_addr_out, exp_chr(int'(ppu[2])));
        check("ciram_a10", bus.ppu_ciram_a10, exp_ciram(int'(ppu)));
        check("wram_cs_lo", bus.prg_wram_cs, 1);
    endtask

    task automatic write_bit(input bit a14, input bit a13, input bit d0);
        bus_cycle(1'b1, 1'b0, a14, a13, 1'b0, 1'b0, 3'b000);
        bus_cycle(1'b0, 1'b0, a14, a13, 1'b0, d0, 3'b000);
    endtask

    task automatic write_reg(input bit a14, input bit a13, input bit [4:0] v);
        for (int i = 0; i < 5; i++) write_bit(a14, a13, v[i]);
    endtask

    // Low-phase probe against hand-derived constants.
    task automatic probe(input string name, input bit a14, input bit [2:0] ppu,
                         input int e_prg, input int e_chr, input int e_ciram);
        bus.cpu_A14 = a14; bus.ppu_addr_in = ppu;
        #1;
        check({name, "_prg"}, bus.prg_addr_out, e_prg);
        check({name, "_chr"}, bus.ppu_addr_out, e_chr);
        check({name, "_ciram"}, bus.ppu_ciram_a10, e_ciram);
    endtask

    task automatic do_reset();
        bus.cpu_rw = 1'b1; bus.romsel = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1 check("lc_async_rst", bus.load_count, 0);
        @(negedge m2); @(negedge m2);
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        bit rw; bit a14; bit a13; bit d7; bit d0; int exp_lc;
    } vec_t;

    vec_t vt[27];
    int   o16;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {rw, A14, A13, D7, D0, expected load_count}
        vt[0]  = '{1, 1, 1, 0, 0, 0};  vt[1]  = '{0, 1, 1, 0, 1, 1};
        vt[2]  = '{1, 1, 1, 0, 0, 1};  vt[3]  = '{0, 1, 1, 0, 0, 2};
        vt[4]  = '{1, 1, 1, 0, 0, 2};  vt[5]  = '{0, 1, 1, 0, 1, 3};
        vt[6]  = '{1, 1, 1, 0, 0, 3};  vt[7]  = '{0, 1, 1, 0, 0, 4};
        vt[8]  = '{1, 1, 1, 0, 0, 4};  vt[9]  = '{0, 1, 1, 0, 0, 0};
        vt[10] = '{1, 0, 1, 0, 0, 0};  vt[11] = '{0, 0, 1, 0, 1, 1};
        vt[12] = '{1, 0, 1, 0, 0, 1};  vt[13] = '{0, 0, 1, 0, 1, 2};
        vt[14] = '{1, 0, 1, 0, 0, 2};  vt[15] = '{0, 0, 1, 1, 0, 0};
        vt[16] = '{1, 0, 1, 0, 0, 0};  vt[17] = '{0, 0, 1, 0, 1, 1};
        vt[18] = '{0, 0, 1, 0, 1, 1};  vt[19] = '{1, 0, 1, 0, 0, 1};
        vt[20] = '{0, 0, 1, 0, 0, 2};  vt[21] = '{1, 0, 1, 0, 0, 2};
        vt[22] = '{0, 0, 1, 0, 0, 3};  vt[23] = '{1, 0, 1, 0, 0, 3};
        vt[24] = '{0, 0, 1, 0, 1, 4};  vt[25] = '{1, 0, 1, 0, 0, 4};
        vt[26] = '{0, 0, 1, 0, 1, 0};
        o16 = HAS_OUTER * 16;

        bus.cpu_rw = 1'b1; bus.romsel = 1'b1; bus.cpu_A14 = 1'b0; bus.cpu_A13 = 1'b0;
        bus.cpu_D7 = 1'b0; bus.cpu_D0 = 1'b0; bus.ppu_addr_in = 3'b000;
        rst_n = 1'b1;
        model_reset();
        #5 rst_n = 1'b0;
        #1 check("lc_in_reset", bus.load_count, 0);
        @(negedge m2); @(negedge m2);
        #2 rst_n = 1'b1;

        // Reset state: mode 11, 8 KB CHR, mirroring 00, empty shift.
        probe("rst_a14_1", 1'b1, 3'b111, 15, 1, 0);
        probe("rst_a14_0", 1'b0, 3'b000, 0, 0, 0);
        check("rst_lc", bus.load_count, 0);
        bus_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        check("rst_wram_on", last_wram_hi, 0);

        // PRG load 00101, D7 reset mid-load, RMW double write, CHR0 load 11001.
        for (int i = 0; i < 27; i++) begin
            bus_cycle(vt[i].rw, 1'b0, vt[i].a14, vt[i].a13, vt[i].d7, vt[i].d0, 3'b100);
            check($sformatf("tbl%0d_lc", i), bus.load_count, vt[i].exp_lc);
        end
        probe("tbl_a14_0", 1'b0, 3'b100, 5 + o16, 25, 0);
        probe("tbl_a14_1", 1'b1, 3'b000, 15 + o16, 24, 0);

        // control=10010 (32 KB PRG, 4 KB CHR, A10 mirroring), chr_bank_1=00111.
        write_reg(1'b0, 1'b0, 5'b10010);
        write_reg(1'b1, 1'b0, 5'b00111);
        probe("c4k_a12_1", 1'b0, 3'b101, 4 + o16, 7, 1);
        probe("c4k_a12_0", 1'b1, 3'b010, 5 + o16, 25, 0);

        // D7 after two bits: only control[3:2] is forced to 11.
        write_bit(1'b0, 1'b0, 1'b1);
        write_bit(1'b0, 1'b0, 1'b0);
        check("d7_pre_lc", bus.load_count, 2);
        bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
        check("d7_lc", bus.load_count, 0);
        probe("d7_a14_1", 1'b1, 3'b001, 15 + o16, 25, 1);
        probe("d7_a14_0", 1'b0, 3'b100, 5 + o16, 7, 0);

        // Reset mid-sequence drops partial bits.
        write_bit(1'b1, 1'b1, 1'b1);
        write_bit(1'b1, 1'b1, 1'b1);
        check("mid_lc", bus.load_count, 2);
        do_reset();
        write_reg(1'b1, 1'b1, 5'b00011);
        probe("mid_prg", 1'b0, 3'b000, 3, 0, 0);

        // prg_bank[4]=1 gates WRAM; chr_bank_0[4] is the outer PRG bit.
        write_reg(1'b1, 1'b1, 5'b10000);
        bus_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        check("wram_gated", last_wram_hi, 1);
        write_reg(1'b0, 1'b1, 5'b10000);
        probe("outer_a14_1", 1'b1, 3'b000, 15 + o16, 16, 0);
        probe("outer_a14_0", 1'b0, 3'b000, o16, 16, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            bus_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
